// File: rtl/maze_solve_gen.sv
`default_nettype none
// ============================================================================
// Module   : maze_solve_gen
// Purpose  : Wall-follower sequencer for the maze robot. It alternates
//            forward moves with heading decisions taken from the IR
//            opening sensors, and waits on the navigation core between
//            steps. Supports left/right/alternate wall preference,
//            straight-through on a front opening, U-turn at dead ends,
//            abort, and a move budget that ends the solve with a failure.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            start, mode     - begin a solve / wall preference (latched)
//            abort           - return to IDLE from any state
//            lft_opn, rght_opn, frnt_opn - sensor openings
//            mv_cmplt        - nav-core completion pulse
//            sol_cmplt       - goal detected
//            strt_hdng, strt_mv - one-cycle command pulses to nav core
//            dsrd_hdng       - desired heading code
//            stp_lft, stp_rght - current side preference
//            busy, sol_done, sol_fail, move_cnt - status
// Revision : 1.0 - initial release
// ============================================================================
module maze_solve_gen #(
    parameter int                HDNG_W      = 12,
    parameter logic [HDNG_W-1:0] HDNG_N      = 12'h000,
    parameter logic [HDNG_W-1:0] HDNG_W_CODE = 12'h3FF,
    parameter logic [HDNG_W-1:0] HDNG_S      = 12'h7FF,
    parameter logic [HDNG_W-1:0] HDNG_E      = 12'hC00,
    parameter int                CNT_W       = 10,
    parameter int                MAX_MOVES   = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              abort,
    input  logic              lft_opn,
    input  logic              rght_opn,
    input  logic              frnt_opn,
    input  logic              mv_cmplt,
    input  logic              sol_cmplt,
    output logic              strt_hdng,
    output logic              strt_mv,
    output logic [HDNG_W-1:0] dsrd_hdng,
    output logic              stp_lft,
    output logic              stp_rght,
    output logic              busy,
    output logic              sol_done,
    output logic              sol_fail,
    output logic [CNT_W-1:0]  move_cnt
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MV        = 3'd1,
        S_WAIT_MV   = 3'd2,
        S_DECIDE    = 3'd3,
        S_WAIT_HDNG = 3'd4,
        S_DONE      = 3'd5,
        S_FAIL      = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] c_max_moves = CNT_W'(MAX_MOVES);

    state_t              r_state;
    logic [1:0]          r_dir_idx;     // N=0, W=1, S=2, E=3 (counter-clockwise)
    logic [HDNG_W-1:0]   r_dsrd_hdng;
    logic                r_pref_left;
    logic                r_alt;
    logic [CNT_W-1:0]    r_move_cnt;
    logic                r_strt_hdng;
    logic                r_strt_mv;

    logic                w_pref_open;
    logic                w_other_open;
    logic                w_turn;
    logic                w_toggle;
    logic [1:0]          w_new_idx;
    logic [CNT_W-1:0]    w_cnt_inc;

    function automatic logic [HDNG_W-1:0] hdng_of(input logic [1:0] idx);
        case (idx)
            2'd0:    hdng_of = HDNG_N;
            2'd1:    hdng_of = HDNG_W_CODE;
            2'd2:    hdng_of = HDNG_S;
            default: hdng_of = HDNG_E;
        endcase
    endfunction

    // Turn decision, evaluated from the openings seen during DECIDE.
    // Left turn is +1, right turn is -1, U-turn is +2 (all mod 4).
    always_comb begin
        w_pref_open  = r_pref_left ? lft_opn  : rght_opn;
        w_other_open = r_pref_left ? rght_opn : lft_opn;
        w_new_idx    = r_dir_idx;
        w_toggle     = 1'b0;
        // A turn happens unless the preferred side is closed and front is open
        w_turn       = w_pref_open | ~frnt_opn;
        if (w_pref_open) begin
            w_new_idx = r_pref_left ? (r_dir_idx + 2'd1) : (r_dir_idx - 2'd1);
            w_toggle  = r_alt;
        end else if (frnt_opn) begin
            w_new_idx = r_dir_idx;
        end else if (w_other_open) begin
            w_new_idx = r_pref_left ? (r_dir_idx - 2'd1) : (r_dir_idx + 2'd1);
            w_toggle  = r_alt;
        end else begin
            // Dead end: U-turn, preference is left alone
            w_new_idx = r_dir_idx + 2'd2;
        end
    end

    assign w_cnt_inc = r_move_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dir_idx   <= 2'd0;
            r_dsrd_hdng <= HDNG_N;
            r_pref_left <= 1'b1;
            r_alt       <= 1'b0;
            r_move_cnt  <= '0;
            r_strt_hdng <= 1'b0;
            r_strt_mv   <= 1'b0;
        end else begin
            r_strt_hdng <= 1'b0;
            r_strt_mv   <= 1'b0;
            if (abort) begin
                // Heading and move count are deliberately kept
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE, S_FAIL: begin
                        if (start) begin
                            r_alt       <= (mode == 2'b10);
                            r_pref_left <= (mode != 2'b01);
                            r_move_cnt  <= '0;
                            r_strt_mv   <= 1'b1;
                            r_state     <= S_MV;
                        end
                    end
                    S_MV: begin
                        r_state <= S_WAIT_MV;
                    end
                    S_WAIT_MV: begin
                        if (sol_cmplt) begin
                            r_state <= S_DONE;
                        end else if (mv_cmplt) begin
                            r_state <= S_DECIDE;
                        end
                    end
                    S_DECIDE: begin
                        if (r_move_cnt != '1) begin
                            r_move_cnt <= w_cnt_inc;
                        end
                        if (w_cnt_inc == c_max_moves) begin
                            r_state <= S_FAIL;
                        end else if (w_turn) begin
                            r_dir_idx   <= w_new_idx;
                            r_dsrd_hdng <= hdng_of(w_new_idx);
                            r_strt_hdng <= 1'b1;
                            if (w_toggle) begin
                                r_pref_left <= ~r_pref_left;
                            end
                            r_state <= S_WAIT_HDNG;
                        end else begin
                            r_strt_mv <= 1'b1;
                            r_state   <= S_MV;
                        end
                    end
                    S_WAIT_HDNG: begin
                        if (sol_cmplt) begin
                            r_state <= S_DONE;
                        end else if (mv_cmplt) begin
                            r_strt_mv <= 1'b1;
                            r_state   <= S_MV;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign strt_hdng = r_strt_hdng;
    assign strt_mv   = r_strt_mv;
    assign dsrd_hdng = r_dsrd_hdng;
    assign stp_lft   = r_pref_left;
    assign stp_rght  = ~r_pref_left;
    assign busy      = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_FAIL);
    assign sol_done  = (r_state == S_DONE);
    assign sol_fail  = (r_state == S_FAIL);
    assign move_cnt  = r_move_cnt;

endmodule
`default_nettype wire

// File: tb/tb_maze_solve_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_maze_solve_gen
// Purpose  : Directed self-checking bench for maze_solve_gen. A default
//            instance covers the main solve behaviour; a second instance
//            with a move budget of 3 covers the failure path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_maze_solve_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        abort = 1'b0;
    logic        lft_opn = 1'b0;
    logic        rght_opn = 1'b0;
    logic        frnt_opn = 1'b0;
    logic        mv_cmplt = 1'b0;
    logic        sol_cmplt = 1'b0;

    logic        strt_hdng, strt_mv, stp_lft, stp_rght, busy, sol_done, sol_fail;
    logic [11:0] dsrd_hdng;
    logic [9:0]  move_cnt;

    logic        f_strt_hdng, f_strt_mv, f_stp_lft, f_stp_rght, f_busy, f_sol_done, f_sol_fail;
    logic [11:0] f_dsrd_hdng;
    logic [9:0]  f_move_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    maze_solve_gen u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
        .lft_opn(lft_opn), .rght_opn(rght_opn), .frnt_opn(frnt_opn),
        .mv_cmplt(mv_cmplt), .sol_cmplt(sol_cmplt),
        .strt_hdng(strt_hdng), .strt_mv(strt_mv), .dsrd_hdng(dsrd_hdng),
        .stp_lft(stp_lft), .stp_rght(stp_rght), .busy(busy),
        .sol_done(sol_done), .sol_fail(sol_fail), .move_cnt(move_cnt)
    );

    maze_solve_gen #(.MAX_MOVES(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
        .lft_opn(lft_opn), .rght_opn(rght_opn), .frnt_opn(frnt_opn),
        .mv_cmplt(mv_cmplt), .sol_cmplt(sol_cmplt),
        .strt_hdng(f_strt_hdng), .strt_mv(f_strt_mv), .dsrd_hdng(f_dsrd_hdng),
        .stp_lft(f_stp_lft), .stp_rght(f_stp_rght), .busy(f_busy),
        .sol_done(f_sol_done), .sol_fail(f_sol_fail), .move_cnt(f_move_cnt)
    );

    // Advance one clock and sample 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [11:0] alt_hdng [4];
        logic        alt_lft  [4];
        alt_hdng = '{12'h3FF, 12'h000, 12'h3FF, 12'h000};
        alt_lft  = '{1'b0, 1'b1, 1'b0, 1'b1};

        // ---------------- reset ----------------
        rst = 1'b1; step(); step(); rst = 1'b0;
        chk("rst_hdng", 32'(dsrd_hdng), 32'h000);
        chk("rst_cnt", 32'(move_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strt_mv", 32'(strt_mv), 32'd0);
        chk("rst_strt_hdng", 32'(strt_hdng), 32'd0);
        chk("rst_done", 32'(sol_done), 32'd0);
        chk("rst_fail", 32'(sol_fail), 32'd0);
        chk("rst_stp_lft", 32'(stp_lft), 32'd1);

        // ---------------- left-wall: left turn ----------------
        mode = 2'b00; start = 1'b1; step(); start = 1'b0;
        chk("t1_strt_mv", 32'(strt_mv), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        step();
        chk("t1_strt_mv_off", 32'(strt_mv), 32'd0);
        step(); step(); step();
        lft_opn = 1'b1; mv_cmplt = 1'b1; step(); mv_cmplt = 1'b0;
        chk("t1_decide_nohdng", 32'(strt_hdng), 32'd0);
        step();
        chk("t1_strt_hdng", 32'(strt_hdng), 32'd1);
        chk("t1_strt_mv_excl", 32'(strt_mv), 32'd0);
        chk("t1_hdng_W", 32'(dsrd_hdng), 32'h3FF);
        chk("t1_cnt", 32'(move_cnt), 32'd1);
        step();
        chk("t1_hdng_pulse_end", 32'(strt_hdng), 32'd0);
        mv_cmplt = 1'b1; step(); mv_cmplt = 1'b0;
        chk("t1_next_mv", 32'(strt_mv), 32'd1);
        lft_opn = 1'b0;

        // ---------------- right-wall: straight then U-turn ----------------
        rst = 1'b1; step(); rst = 1'b0;
        mode = 2'b01; start = 1'b1; step(); start = 1'b0;
        chk("t2_stp_lft", 32'(stp_lft), 32'd0);
        chk("t2_stp_rght", 32'(stp_rght), 32'd1);
        step();
        lft_opn = 1'b1; rght_opn = 1'b0; frnt_opn = 1'b1; mv_cmplt = 1'b1;
        step(); mv_cmplt = 1'b0;
        step();
        chk("t2_straight_mv", 32'(strt_mv), 32'd1);
        chk("t2_straight_nohdng", 32'(strt_hdng), 32'd0);
        chk("t2_straight_hdng", 32'(dsrd_hdng), 32'h000);
        step();
        lft_opn = 1'b0; frnt_opn = 1'b0; mv_cmplt = 1'b1;
        step(); mv_cmplt = 1'b0;
        step();
        chk("t2_uturn_pulse", 32'(strt_hdng), 32'd1);
        chk("t2_uturn_hdng", 32'(dsrd_hdng), 32'h7FF);
        chk("t2_uturn_cnt", 32'(move_cnt), 32'd2);
        chk("t2_uturn_pref", 32'(stp_lft), 32'd0);

        // ---------------- alternate mode ----------------
        rst = 1'b1; step(); rst = 1'b0;
        mode = 2'b10; start = 1'b1; step(); start = 1'b0;
        chk("t3_pref0", 32'(stp_lft), 32'd1);
        lft_opn = 1'b1; rght_opn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            mv_cmplt = 1'b1; step(); mv_cmplt = 1'b0;
            step();
            chk($sformatf("t3_pulse%0d", i), 32'(strt_hdng), 32'd1);
            chk($sformatf("t3_hdng%0d", i), 32'(dsrd_hdng), 32'(alt_hdng[i]));
            chk($sformatf("t3_lft%0d", i), 32'(stp_lft), 32'(alt_lft[i]));
            mv_cmplt = 1'b1; step(); mv_cmplt = 1'b0;
        end
        lft_opn = 1'b0; rght_opn = 1'b0;

        // ---------------- move budget (instance with MAX_MOVES=3) -------
        rst = 1'b1; step(); rst = 1'b0;
        mode = 2'b00; start = 1'b1; step(); start = 1'b0;
        step();
        frnt_opn = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            mv_cmplt = 1'b1; step(); mv_cmplt = 1'b0;
            step();
            if (k < 3) step();
        end
        chk("t4_fail", 32'(f_sol_fail), 32'd1);
        chk("t4_cnt", 32'(f_move_cnt), 32'd3);
        chk("t4_busy", 32'(f_busy), 32'd0);
        chk("t4_no_mv", 32'(f_strt_mv), 32'd0);
        chk("t4_no_hdng", 32'(f_strt_hdng), 32'd0);
        mv_cmplt = 1'b1; step(); step(); mv_cmplt = 1'b0;
        chk("t4_hold_fail", 32'(f_sol_fail), 32'd1);
        chk("t4_hold_no_mv", 32'(f_strt_mv), 32'd0);
        chk("t4_hold_cnt", 32'(f_move_cnt), 32'd3);
        frnt_opn = 1'b0;

        // ---------------- goal beats move completion ----------------
        rst = 1'b1; step(); rst = 1'b0;
        mode = 2'b00; start = 1'b1; step(); start = 1'b0;
        step();
        lft_opn = 1'b1; sol_cmplt = 1'b1; mv_cmplt = 1'b1;
        step(); sol_cmplt = 1'b0; mv_cmplt = 1'b0;
        chk("t5_done", 32'(sol_done), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        step();
        chk("t5_no_hdng", 32'(strt_hdng), 32'd0);
        chk("t5_hold_done", 32'(sol_done), 32'd1);
        chk("t5_cnt", 32'(move_cnt), 32'd0);

        // ---------------- abort in WAIT_HDNG, then reset ----------------
        start = 1'b1; step(); start = 1'b0;
        step();
        mv_cmplt = 1'b1; step(); mv_cmplt = 1'b0;
        step();
        chk("t6_hdng_pulse", 32'(strt_hdng), 32'd1);
        chk("t6_hdng_W", 32'(dsrd_hdng), 32'h3FF);
        abort = 1'b1; step(); abort = 1'b0;
        chk("t6_abort_busy", 32'(busy), 32'd0);
        chk("t6_abort_hdng", 32'(dsrd_hdng), 32'h3FF);
        chk("t6_abort_cnt", 32'(move_cnt), 32'd1);
        chk("t6_abort_no_hdng", 32'(strt_hdng), 32'd0);
        chk("t6_abort_no_mv", 32'(strt_mv), 32'd0);
        start = 1'b1; step(); start = 1'b0;
        chk("t6_restart_mv", 32'(strt_mv), 32'd1);
        chk("t6_restart_hdng", 32'(dsrd_hdng), 32'h3FF);
        step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("t6_rst_hdng", 32'(dsrd_hdng), 32'h000);
        chk("t6_rst_cnt", 32'(move_cnt), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_mv", 32'(strt_mv), 32'd0);
        chk("t6_rst_hdng_p", 32'(strt_hdng), 32'd0);
        chk("t6_rst_done", 32'(sol_done), 32'd0);
        chk("t6_rst_fail", 32'(sol_fail), 32'd0);
        lft_opn = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/maze_solve_gen.md
Name: maze_solve_gen

Overview:
- Parametrised wall-follower sequencer for the maze robot. Successor to the fixed left/right solver.
- Sits between the command/IR-sensor front end and the navigation core: issues heading changes and forward moves, and waits for nav completion.
- New over the previous generation: front-opening awareness (straight-through), explicit U-turn at dead ends, alternate-preference mode, abort, move budget with failure flag, configurable heading codes and width.

Parameters:
- HDNG_W, 12, width of the heading bus.
- HDNG_N, 12'h000, north code.
- HDNG_W_CODE, 12'h3FF, west code.
- HDNG_S, 12'h7FF, south code.
- HDNG_E, 12'hC00, east code.
- CNT_W, 10, width of the move counter.
- MAX_MOVES, 1000, move budget; reaching it ends the solve with a failure (must be < 2^CNT_W).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a solve, sampled only in IDLE/DONE/FAIL.
- mode  in  2  latched at start: 00 left-wall, 01 right-wall, 10 alternate (begins left), 11 treated as 00.
- abort  in  1  forces IDLE next cycle from any state.
- lft_opn  in  1  left side open.
- rght_opn  in  1  right side open.
- frnt_opn  in  1  front open.
- mv_cmplt  in  1  nav-core completion pulse (heading or move done).
- sol_cmplt  in  1  magnet/goal detected.
- strt_hdng  out  1  one-cycle pulse; load new heading.
- strt_mv  out  1  one-cycle pulse; start forward move.
- dsrd_hdng  out  HDNG_W  registered desired heading.
- stp_lft  out  1  1 when current preference is left.
- stp_rght  out  1  inverse of stp_lft.
- busy  out  1  high in all states except IDLE, DONE, FAIL.
- sol_done  out  1  level, high in DONE.
- sol_fail  out  1  level, high in FAIL.
- move_cnt  out  CNT_W  number of DECIDE cycles since start.

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE; dsrd_hdng=HDNG_N; dir_idx=0; pref=left; move_cnt=0; all pulses, sol_done and sol_fail 0.
- Heading index: 2-bit dir_idx with N=0, W=1, S=2, E=3 (CCW).
  - Left turn: +1 mod 4. Right turn: −1 mod 4. U-turn: +2 mod 4.
  - dsrd_hdng is a registered LUT of dir_idx and updates in the same cycle strt_hdng asserts.
- States: IDLE, MV, WAIT_MV, DECIDE, WAIT_HDNG, DONE, FAIL.
- IDLE/DONE/FAIL on start:
  - Latch mode; set pref from mode; clear move_cnt and flags.
  - Heading is retained (not re-centred to north).
  - Go to MV.
- MV: strt_mv=1 for exactly this cycle, then WAIT_MV.
- WAIT_MV:
  - sol_cmplt → DONE. sol_cmplt has priority over a same-cycle mv_cmplt.
  - Else mv_cmplt → DECIDE.
- DECIDE: one cycle; evaluates the open inputs sampled this cycle; move_cnt += 1 (saturating).
  - If move_cnt+1 == MAX_MOVES → FAIL, no pulse.
  - Else, in priority order:
    - preferred side open → turn to that side;
    - else frnt_opn → no turn, go to MV (no strt_hdng);
    - else other side open → turn to that side;
    - else → U-turn.
  - Any turn: update dir_idx/dsrd_hdng, strt_hdng=1 this cycle, go to WAIT_HDNG.
  - Alternate mode: pref toggles on every turn except U-turns.
- WAIT_HDNG:
  - sol_cmplt → DONE.
  - Else mv_cmplt → MV.
- DONE/FAIL: hold outputs until start or rst.
- abort: state → IDLE next edge, with no strt_hdng/strt_mv that cycle. dsrd_hdng and move_cnt are held. Priority: rst > abort > everything else.
- mv_cmplt seen in IDLE/MV/DECIDE/DONE/FAIL is ignored.
- stp_lft/stp_rght are combinational from pref.
- strt_hdng and strt_mv are never high in the same cycle.

Test Plan:
- Reset, start mode=00, mv_cmplt after 5 cycles with lft_opn=1 → strt_mv at cycle 1; DECIDE gives strt_hdng with dsrd_hdng=12'h3FF; next mv_cmplt → strt_mv.
- Mode=01, heading N, lft=1, rght=0, frnt=1 at DECIDE → no strt_hdng, strt_mv next cycle, dsrd_hdng stays 12'h000. Then all closed → U-turn, dsrd_hdng=12'h7FF.
- Mode=10, four decisions with both sides open → turns L, R, L, R; dsrd_hdng N→W→N→W→N; stp_lft toggles 1,0,1,0.
- MAX_MOVES=3, never reach goal → third DECIDE enters FAIL; sol_fail=1, move_cnt=3, no further pulses.
- sol_cmplt and mv_cmplt in the same WAIT_MV cycle → DONE, sol_done=1, no strt_hdng.
- abort in WAIT_HDNG, then rst mid-solve → IDLE with heading held after abort; after rst, dsrd_hdng=12'h000, move_cnt=0, all outputs 0.
